// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator.
// Mode, FSM state and ping-pong direction types.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_PONG  = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: strobes tick on the last count of each
// CLK_DIV-cycle window while run is high; clr restarts it.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chaser, ping-pong and
// counter patterns with prescaled stepping and PWM dimming.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int CLK_DIV  = 25000000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LED-1:0]    LED,
  output logic                tick,
  output logic                wrap
);

  state_e state, nxt;
  mode_e  mode_i, mode_q;
  dir_e   dir, dir_n;

  logic [N_LED-1:0]    pattern, pat_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                step, run, clr;
  logic                mchg, pwm_on;

  function automatic logic [N_LED-1:0] init_pat(
    input mode_e m
  );
    unique case (m)
      MODE_BLINK: init_pat = '1;
      MODE_COUNT: init_pat = '0;
      default:    init_pat = N_LED'(1);
    endcase
  endfunction

  assign mode_i = mode_e'(mode);
  assign mchg   = (mode_i != mode_q);
  assign pwm_on = (&duty) | (pwm_cnt < duty);

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tick (step)
  );

  always_comb begin
    nxt = state;
    clr = 1'b0;
    run = 1'b0;
    unique case (state)
      IDLE: if (en) nxt = LOAD;
      LOAD: begin
        clr = 1'b1;
        nxt = en ? RUN : HOLD;
      end
      RUN: begin
        if (mchg)     nxt = LOAD;
        else if (!en) nxt = HOLD;
        else          run = 1'b1;
      end
      HOLD: begin
        if (mchg)    nxt = LOAD;
        else if (en) nxt = RUN;
      end
      default: nxt = IDLE;
    endcase
  end

  // Ping-pong turns around on the step that lands on an end bit.
  always_comb begin
    pat_n = pattern;
    dir_n = dir;
    unique case (mode_q)
      MODE_BLINK: pat_n = ~pattern;
      MODE_CHASE: pat_n = {pattern[N_LED-2:0],
                           pattern[N_LED-1]};
      MODE_PONG: begin
        if (dir == DIR_UP) begin
          pat_n = pattern << 1;
          if (pat_n[N_LED-1]) dir_n = DIR_DN;
        end else begin
          pat_n = pattern >> 1;
          if (pat_n[0]) dir_n = DIR_UP;
        end
      end
      MODE_COUNT: pat_n = pattern + 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mode_q  <= MODE_BLINK;
      dir     <= DIR_UP;
      pattern <= '0;
      pwm_cnt <= '0;
      LED     <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state <= nxt;
      tick  <= step;
      wrap  <= step && (pat_n == init_pat(mode_q));
      if (state == LOAD) begin
        mode_q  <= mode_i;
        pattern <= init_pat(mode_i);
        dir     <= DIR_UP;
      end else if (step) begin
        pattern <= pat_n;
        dir     <= dir_n;
      end
      if (state != IDLE) pwm_cnt <= pwm_cnt + 1'b1;
      LED <= (state == IDLE) ? '0
           : pattern & {N_LED{pwm_on}};
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N_LED=8, CLK_DIV=4).
// Step tables per pattern plus hand sequences for corner cases.
module tb_led_pattern_gen;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       en   = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] duty = 4'd15;
  logic [7:0] LED;
  logic       tick, wrap;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  typedef struct {
    logic [7:0] led;
    logic       w;
    int         gap;
  } vec_t;

  vec_t chase[8];
  vec_t pong[15];

  led_pattern_gen #(
    .N_LED    (8),
    .CLK_DIV  (4),
    .PWM_BITS (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .duty (duty),
    .LED  (LED),
    .tick (tick),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  // clock edges since reset release; drives the PWM phase model
  always @(posedge clk or negedge rst)
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm,
                      input logic [7:0] el,
                      input logic ew,
                      input int gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 40);
    if (!tick) begin
      total++;
      bad++;
      $display("FAIL %s tick timeout: got none want tick", nm);
      return;
    end
    chk({nm, " gap"}, n, gap);
    chk({nm, " wrap"}, wrap, ew);
    @(negedge clk);
    chk({nm, " led"}, LED, el);
    chk({nm, " tick pulse"}, tick, 1'b0);
    chk({nm, " wrap pulse"}, wrap, 1'b0);
  endtask

  initial begin
    chase = '{
      '{8'h02, 1'b0, 3}, '{8'h04, 1'b0, 3},
      '{8'h08, 1'b0, 3}, '{8'h10, 1'b0, 3},
      '{8'h20, 1'b0, 3}, '{8'h40, 1'b0, 3},
      '{8'h80, 1'b0, 3}, '{8'h01, 1'b1, 3}
    };
    pong = '{
      '{8'h02, 1'b0, 6}, '{8'h04, 1'b0, 3},
      '{8'h08, 1'b0, 3}, '{8'h10, 1'b0, 3},
      '{8'h20, 1'b0, 3}, '{8'h40, 1'b0, 3},
      '{8'h80, 1'b0, 3}, '{8'h40, 1'b0, 3},
      '{8'h20, 1'b0, 3}, '{8'h10, 1'b0, 3},
      '{8'h08, 1'b0, 3}, '{8'h04, 1'b0, 3},
      '{8'h02, 1'b0, 3}, '{8'h01, 1'b1, 3},
      '{8'h02, 1'b0, 3}
    };

    // reset state
    @(negedge clk);
    chk("rst led", LED, 8'h00);
    chk("rst tick", tick, 1'b0);
    chk("rst wrap", wrap, 1'b0);

    mode = 2'd1;
    en   = 1'b1;
    rst  = 1'b1;
    repeat (20) @(negedge clk);
    chk("run led", LED, 8'h10);

    // asynchronous reset mid-run
    #2 rst = 1'b0;
    #1;
    chk("async led", LED, 8'h00);
    chk("async tick", tick, 1'b0);
    chk("async wrap", wrap, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle->load led", LED, 8'h00);
    @(negedge clk);
    chk("load->run led", LED, 8'h00);
    @(negedge clk);
    chk("first chase led", LED, 8'h01);

    for (int i = 0; i < 8; i++)
      step("chase", chase[i].led, chase[i].w, chase[i].gap);

    mode = 2'd2;
    for (int i = 0; i < 15; i++)
      step("pong", pong[i].led, pong[i].w, pong[i].gap);

    mode = 2'd3;
    for (int i = 0; i < 256; i++)
      step("count", 8'((i + 1) & 255), i == 255,
           (i == 0) ? 6 : 3);

    // blink after a mode change
    mode = 2'd0;
    @(negedge clk);
    chk("blink load led", LED, 8'h00);
    @(negedge clk);
    chk("blink run0 led", LED, 8'h00);
    @(negedge clk);
    chk("blink init led", LED, 8'hFF);
    step("blink", 8'h00, 1'b0, 3);
    step("blink", 8'hFF, 1'b1, 3);
    step("blink", 8'h00, 1'b0, 3);
    step("blink", 8'hFF, 1'b1, 3);

    // pause and resume in chaser
    mode = 2'd1;
    step("chase2", 8'h02, 1'b0, 6);
    step("chase2", 8'h04, 1'b0, 3);
    step("chase2", 8'h08, 1'b0, 3);
    en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("hold led", LED, 8'h08);
      chk("hold tick", tick, 1'b0);
    end
    en = 1'b1;
    step("resume", 8'h10, 1'b0, 4);

    // mode change while held reloads but does not step
    en = 1'b0;
    @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold reload led", LED, 8'h00);
      chk("hold reload tick", tick, 1'b0);
    end
    en = 1'b1;
    step("count2", 8'h01, 1'b0, 5);
    step("count2", 8'h02, 1'b0, 3);
    step("count2", 8'h03, 1'b0, 3);

    // PWM on a frozen pattern of 0x03
    en = 1'b0;
    @(negedge clk);
    duty = 4'd4;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("pwm duty4", LED,
          (((ecnt - 2) % 16) < 4) ? 32'h03 : 32'h00);
    end
    duty = 4'd0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("pwm duty0", LED, 8'h00);
    end
    duty = 4'd15;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("pwm duty15", LED, 8'h03);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
